// File: rtl/fwd_pkg.sv
// Shared types and constants for the EX-stage data-hazard forwarding unit.
package fwd_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_EX   = 2'b10
  } fwd_sel_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/fwd_sel_one.sv
// Per-operand forwarding comparator: picks EX/MEM, MEM/WB or the register file for one Rs.
module fwd_sel_one
  import fwd_pkg::*;
(
  input  logic       ex_we_i,
  input  logic [4:0] ex_rd_i,
  input  logic       wb_we_i,
  input  logic [4:0] wb_rd_i,
  input  logic [4:0] rs_i,
  output fwd_sel_e   sel_o
);

  logic ex_hit;
  logic wb_hit;

  // x0 is hard-wired to zero, so a write targeting it never produces a forward.
  assign ex_hit = ex_we_i && (ex_rd_i != REG_X0) && (ex_rd_i == rs_i);
  assign wb_hit = wb_we_i && (wb_rd_i != REG_X0) && (wb_rd_i == rs_i);

  always_comb begin
    sel_o = FWD_NONE;
    if (ex_hit) begin
      sel_o = FWD_EX;
    end else if (wb_hit) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_logic.sv
// Forwarding unit beside the EX stage: combinational ALU-operand selects, plus optional
// saturating forwarding-event counters compiled in when FWD_STATS_EN is defined.
module fwd_logic
  import fwd_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EX_MEM_RegWrite,
  input  logic [4:0]       EX_MEM_Rd,
  input  logic             MEM_WB_RegWrite,
  input  logic [4:0]       MEM_WB_Rd,
  input  logic [4:0]       ID_EX_Rs1,
  input  logic [4:0]       ID_EX_Rs2,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB
`ifdef FWD_STATS_EN
  ,
  output logic [CNT_W-1:0] fwd_ex_cnt,
  output logic [CNT_W-1:0] fwd_wb_cnt
`endif
);

  fwd_sel_e sel_a;
  fwd_sel_e sel_b;

  fwd_sel_one u_sel_a (
    .ex_we_i (EX_MEM_RegWrite),
    .ex_rd_i (EX_MEM_Rd),
    .wb_we_i (MEM_WB_RegWrite),
    .wb_rd_i (MEM_WB_Rd),
    .rs_i    (ID_EX_Rs1),
    .sel_o   (sel_a)
  );

  fwd_sel_one u_sel_b (
    .ex_we_i (EX_MEM_RegWrite),
    .ex_rd_i (EX_MEM_Rd),
    .wb_we_i (MEM_WB_RegWrite),
    .wb_rd_i (MEM_WB_Rd),
    .rs_i    (ID_EX_Rs2),
    .sel_o   (sel_b)
  );

  assign forwardA = sel_a;
  assign forwardB = sel_b;

`ifdef FWD_STATS_EN
  logic [1:0][CNT_W-1:0] cnt_vec;

  // Counter 0 tracks EX/MEM forwards, counter 1 tracks MEM/WB forwards.
  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    localparam fwd_sel_e KIND = (gi == 0) ? FWD_EX : FWD_WB;

    logic [1:0]       inc;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
      inc   = {1'b0, (sel_a == KIND)} + {1'b0, (sel_b == KIND)};
      sum   = {1'b0, cnt_q} + {{(CNT_W-1){1'b0}}, inc};
      cnt_d = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign cnt_vec[gi] = cnt_q;
  end

  assign fwd_ex_cnt = cnt_vec[0];
  assign fwd_wb_cnt = cnt_vec[1];
`else
  logic             unused_ctl;
  logic [CNT_W-1:0] unused_cnt;
  assign unused_ctl = clk ^ rst;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_logic.sv
// Directed self-checking bench for fwd_logic; counter checks run when FWD_STATS_EN is defined.
module tb_fwd_logic;

  logic       clk;
  logic       rst;
  logic       ex_we;
  logic [4:0] ex_rd;
  logic       wb_we;
  logic [4:0] wb_rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
`ifdef FWD_STATS_EN
  logic [3:0] ex_cnt;
  logic [3:0] wb_cnt;
`endif

  int errors = 0;
  int checks = 0;

  fwd_logic #(.CNT_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .EX_MEM_RegWrite (ex_we),
    .EX_MEM_Rd       (ex_rd),
    .MEM_WB_RegWrite (wb_we),
    .MEM_WB_Rd       (wb_rd),
    .ID_EX_Rs1       (rs1),
    .ID_EX_Rs2       (rs2),
    .forwardA        (fwd_a),
    .forwardB        (fwd_b)
`ifdef FWD_STATS_EN
    ,
    .fwd_ex_cnt      (ex_cnt),
    .fwd_wb_cnt      (wb_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic ew, input logic [4:0] erd, input logic ww,
                       input logic [4:0] wrd, input logic [4:0] s1, input logic [4:0] s2);
    ex_we = ew; ex_rd = erd; wb_we = ww; wb_rd = wrd; rs1 = s1; rs2 = s2;
    #1;
  endtask

  task automatic sel(input string tag, input logic [1:0] ea, input logic [1:0] eb);
    check({tag, ".A"}, {30'd0, fwd_a}, {30'd0, ea});
    check({tag, ".B"}, {30'd0, fwd_b}, {30'd0, eb});
    $display("step %s: A=%b B=%b", tag, fwd_a, fwd_b);
  endtask

  initial begin
    rst = 1'b1;
    apply(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    sel("idle_rst", 2'b00, 2'b00);
    // selects must follow inputs even while reset is held
    apply(1'b1, 5'd10, 1'b0, 5'd0, 5'd10, 5'd0);
    sel("in_rst", 2'b10, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0;

    apply(1'b1, 5'd10, 1'b0, 5'd0, 5'd10, 5'd0);
    sel("ex_fwd", 2'b10, 2'b00);
    apply(1'b0, 5'd0, 1'b1, 5'd11, 5'd11, 5'd0);
    sel("wb_fwd", 2'b01, 2'b00);
    apply(1'b1, 5'd10, 1'b1, 5'd11, 5'd11, 5'd10);
    sel("mixed", 2'b01, 2'b10);
    apply(1'b1, 5'd12, 1'b1, 5'd12, 5'd0, 5'd12);
    sel("prio_ex", 2'b00, 2'b10);
    apply(1'b0, 5'd12, 1'b1, 5'd12, 5'd0, 5'd12);
    sel("prio_wb", 2'b00, 2'b01);
    apply(1'b1, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0);
    sel("x0", 2'b00, 2'b00);
    apply(1'b0, 5'd5, 1'b0, 5'd6, 5'd5, 5'd6);
    sel("we_off", 2'b00, 2'b00);
    apply(1'b1, 5'd7, 1'b1, 5'd8, 5'd9, 5'd6);
    sel("nomatch", 2'b00, 2'b00);
    apply(1'b1, 5'd31, 1'b0, 5'd0, 5'd31, 5'd31);
    sel("both_ex", 2'b10, 2'b10);
    apply(1'b0, 5'd31, 1'b1, 5'd3, 5'd3, 5'd3);
    sel("both_wb", 2'b01, 2'b01);

`ifdef FWD_STATS_EN
    rst = 1'b1;
    apply(1'b1, 5'd10, 1'b1, 5'd11, 5'd11, 5'd10);
    @(posedge clk); #1;
    check("cnt_rst_ex", {28'd0, ex_cnt}, 32'd0);
    check("cnt_rst_wb", {28'd0, wb_cnt}, 32'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("cnt3_ex", {28'd0, ex_cnt}, 32'd3);
    check("cnt3_wb", {28'd0, wb_cnt}, 32'd3);
    $display("stats after 3 mixed: ex=%0d wb=%0d", ex_cnt, wb_cnt);

    apply(1'b1, 5'd10, 1'b0, 5'd0, 5'd10, 5'd0);
    repeat (20) @(posedge clk);
    #1;
    check("sat_ex", {28'd0, ex_cnt}, 32'd15);
    check("hold_wb", {28'd0, wb_cnt}, 32'd3);
    $display("stats after 20 ex: ex=%0d wb=%0d", ex_cnt, wb_cnt);

    // +2 per cycle from 14 must clamp at 15 rather than wrap
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    apply(1'b1, 5'd31, 1'b0, 5'd0, 5'd31, 5'd31);
    repeat (7) @(posedge clk);
    #1;
    check("dbl_ex14", {28'd0, ex_cnt}, 32'd14);
    @(posedge clk); #1;
    check("dbl_sat", {28'd0, ex_cnt}, 32'd15);
    check("dbl_wb0", {28'd0, wb_cnt}, 32'd0);

    rst = 1'b1;
    apply(1'b0, 5'd31, 1'b1, 5'd3, 5'd3, 5'd3);
    @(posedge clk); #1;
    check("rst_clr_ex", {28'd0, ex_cnt}, 32'd0);
    check("rst_clr_wb", {28'd0, wb_cnt}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_wb", {28'd0, wb_cnt}, 32'd2);
    $display("stats after reset: ex=%0d wb=%0d", ex_cnt, wb_cnt);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
